// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-side hazard unit.
//   REG_ADDR_W     : default register index width
//   FWD_RF         : forwarding select value meaning "read the register file"
//   FWD_STAGE_BASE : select value of the youngest forwarding stage
//   fwd_sel_t      : select type for the default three-stage configuration
package hazard_pkg;

  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned FWD_RF         = 0;
  localparam int unsigned FWD_STAGE_BASE = 1;

  localparam int unsigned DEF_NUM_FWD = 3;
  localparam int unsigned FWD_SEL_W   = $clog2(DEF_NUM_FWD + 1);

  typedef logic [FWD_SEL_W-1:0]  fwd_sel_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_if.sv
// Bundle between the pipeline (master) and the hazard unit (slave).
//   master drives : decode sources, per-stage rd/regwrite/valid,
//                   long-latency issue/done, branch redirect
//   slave drives  : fwd_A/fwd_B selects, stall/flush controls, stall_count
interface hazard_if #(
  parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int unsigned NUM_FWD    = 3,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  logic [REG_ADDR_W-1:0]              rs1_decode;
  logic [REG_ADDR_W-1:0]              rs2_decode;
  logic                               rs1_used;
  logic                               rs2_used;
  logic [NUM_FWD-1:0][REG_ADDR_W-1:0] rd_stage;
  logic [NUM_FWD-1:0]                 regwrite_stage;
  logic [NUM_FWD-1:0]                 data_valid_stage;
  logic                               lc_issue;
  logic [REG_ADDR_W-1:0]              lc_rd;
  logic                               lc_done;
  logic [REG_ADDR_W-1:0]              lc_done_rd;
  logic                               branch_taken_exe;

  logic [SEL_W-1:0]                   fwd_A;
  logic [SEL_W-1:0]                   fwd_B;
  logic                               stall_decode;
  logic                               flush_decode;
  logic                               flush_exe;
  logic [CNT_W-1:0]                   stall_count;

  modport master (
    output rs1_decode, rs2_decode, rs1_used, rs2_used, rd_stage, regwrite_stage,
           data_valid_stage, lc_issue, lc_rd, lc_done, lc_done_rd, branch_taken_exe,
    input  fwd_A, fwd_B, stall_decode, flush_decode, flush_exe, stall_count
  );

  modport slave (
    input  rs1_decode, rs2_decode, rs1_used, rs2_used, rd_stage, regwrite_stage,
           data_valid_stage, lc_issue, lc_rd, lc_done, lc_done_rd, branch_taken_exe,
    output fwd_A, fwd_B, stall_decode, flush_decode, flush_exe, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-result bit per register for long-latency operations.
//   set_i/set_addr_i     : mark a register pending (wins over a same-cycle clear)
//   clr_i/clr_addr_i     : result written back, release the register
//   rd_a/rd_b_addr_i     : combinational read ports for the two decode sources
//   waw_addr_i           : combinational read port for the issuing destination
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_a_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_b_addr_i,
  input  logic [REG_ADDR_W-1:0] waw_addr_i,
  output logic                  rd_a_pend_o,
  output logic                  rd_b_pend_o,
  output logic                  waw_pend_o
);
  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic [NUM_REGS-1:0] pend_q, pend_d;

  // Clear first so a younger issue to the same register survives.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign rd_a_pend_o = pend_q[rd_a_addr_i];
  assign rd_b_pend_o = pend_q[rd_b_addr_i];
  assign waw_pend_o  = pend_q[waw_addr_i];

endmodule

// File: rtl/hazard_unit.sv
// Decode-side hazard unit: youngest-first forwarding over NUM_FWD stages,
// load-use and scoreboard stalls, WAW stall, branch flush, stall counter.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : hazard_if slave (decode sources, stage info, lc issue/done,
//              branch in; fwd selects, stall/flush, stall_count out)
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int unsigned NUM_FWD    = 3,
  parameter int unsigned CNT_W      = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  logic [NUM_FWD-1:0] hit_a, hit_b;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               lu_a, lu_b;
  logic               pend_a, pend_b, pend_waw;
  logic               stall_raw, stall_c, flush_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Per-stage match; rd = x0 never matches, so rs = x0 never forwards or stalls.
  for (genvar k = 0; k < NUM_FWD; k++) begin : g_match
    logic wr_k;
    assign wr_k     = bus.regwrite_stage[k] && (bus.rd_stage[k] != '0);
    assign hit_a[k] = wr_k && bus.rs1_used && (bus.rd_stage[k] == bus.rs1_decode);
    assign hit_b[k] = wr_k && bus.rs2_used && (bus.rd_stage[k] == bus.rs2_decode);
  end

  // Returns {load_use, sel}; scanning oldest to youngest lets the youngest hit win.
  function automatic logic [SEL_W:0] pick(input logic [NUM_FWD-1:0] hit,
                                          input logic [NUM_FWD-1:0] vld);
    logic [SEL_W:0] r;
    r = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit[k]) begin
        if (vld[k]) r = {1'b0, SEL_W'(32'(k) + FWD_STAGE_BASE)};
        else        r = {1'b1, SEL_W'(FWD_RF)};
      end
    end
    return r;
  endfunction

  assign {lu_a, sel_a} = pick(hit_a, bus.data_valid_stage);
  assign {lu_b, sel_b} = pick(hit_b, bus.data_valid_stage);

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_i       (bus.lc_issue && !stall_c && !flush_c),
    .set_addr_i  (bus.lc_rd),
    .clr_i       (bus.lc_done),
    .clr_addr_i  (bus.lc_done_rd),
    .rd_a_addr_i (bus.rs1_decode),
    .rd_b_addr_i (bus.rs2_decode),
    .waw_addr_i  (bus.lc_rd),
    .rd_a_pend_o (pend_a),
    .rd_b_pend_o (pend_b),
    .waw_pend_o  (pend_waw)
  );

  assign stall_raw = lu_a || lu_b
                  || (bus.rs1_used && pend_a)
                  || (bus.rs2_used && pend_b)
                  || (bus.lc_issue && pend_waw);

  // A taken branch squashes decode anyway, so it overrides any stall.
  assign flush_c = !rst && bus.branch_taken_exe;
  assign stall_c = !rst && !bus.branch_taken_exe && stall_raw;

  assign bus.fwd_A        = rst ? SEL_W'(FWD_RF) : sel_a;
  assign bus.fwd_B        = rst ? SEL_W'(FWD_RF) : sel_b;
  assign bus.stall_decode = stall_c;
  assign bus.flush_decode = flush_c;
  assign bus.flush_exe    = flush_c;

  // Saturating performance counter of stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the hazard rules.
module tb_hazard_unit;
  localparam int unsigned AW = 5;
  localparam int unsigned NF = 3;
  localparam int unsigned CW = 16;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  bit          pend_m[2**AW];
  int unsigned cnt_m;

  hazard_if #(.REG_ADDR_W(AW), .NUM_FWD(NF), .CNT_W(CW)) hif ();

  hazard_unit #(.REG_ADDR_W(AW), .NUM_FWD(NF), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First stage (youngest first) writing rs decides the outcome.
  function automatic void fwd_ref(input logic [AW-1:0] rs, input logic used,
                                  output int sel, output bit lu);
    sel = 0;
    lu  = 1'b0;
    if (!used || rs == 0) return;
    for (int k = 0; k < NF; k++) begin
      if (hif.regwrite_stage[k] && hif.rd_stage[k] == rs) begin
        if (hif.data_valid_stage[k]) sel = k + 1;
        else                         lu  = 1'b1;
        return;
      end
    end
  endfunction

  task automatic set_idle();
    rst                  = 1'b0;
    hif.rs1_decode       = '0;
    hif.rs2_decode       = '0;
    hif.rs1_used         = 1'b0;
    hif.rs2_used         = 1'b0;
    hif.rd_stage         = '0;
    hif.regwrite_stage   = '0;
    hif.data_valid_stage = '0;
    hif.lc_issue         = 1'b0;
    hif.lc_rd            = '0;
    hif.lc_done          = 1'b0;
    hif.lc_done_rd       = '0;
    hif.branch_taken_exe = 1'b0;
  endtask

  // Compare all outputs against the model for the current inputs, then advance one cycle.
  task automatic step();
    int sa, sb;
    bit la, lb, st, fl;
    #1;
    fwd_ref(hif.rs1_decode, hif.rs1_used, sa, la);
    fwd_ref(hif.rs2_decode, hif.rs2_used, sb, lb);
    fl = !rst && hif.branch_taken_exe;
    st = !rst && !hif.branch_taken_exe &&
         (la || lb || (hif.rs1_used && pend_m[hif.rs1_decode])
                   || (hif.rs2_used && pend_m[hif.rs2_decode])
                   || (hif.lc_issue && pend_m[hif.lc_rd]));
    if (rst) begin
      sa = 0;
      sb = 0;
    end
    check("fwd_A", 32'(hif.fwd_A), 32'(sa));
    check("fwd_B", 32'(hif.fwd_B), 32'(sb));
    check("stall_decode", 32'(hif.stall_decode), 32'(st));
    check("flush_decode", 32'(hif.flush_decode), 32'(fl));
    check("flush_exe", 32'(hif.flush_exe), 32'(fl));
    check("stall_count", 32'(hif.stall_count), cnt_m);
    @(posedge clk);
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      cnt_m = 0;
    end else begin
      if (hif.lc_done) pend_m[hif.lc_done_rd] = 1'b0;
      if (hif.lc_issue && !st && !fl && hif.lc_rd != 0) pend_m[hif.lc_rd] = 1'b1;
      if (st && cnt_m < (2**CW - 1)) cnt_m++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    cnt_m = 0;
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    set_idle();
    #1 check("reset_count", 32'(hif.stall_count), 32'd0);

    // Multi-stage forwarding with youngest-first priority.
    hif.rd_stage = {5'd5, 5'd5, 5'd5};
    hif.regwrite_stage = 3'b111;
    hif.data_valid_stage = 3'b111;
    hif.rs1_decode = 5'd5;
    hif.rs1_used = 1'b1;
    #1 check("fwd_exe", 32'(hif.fwd_A), 32'd1);
    step();
    hif.regwrite_stage[0] = 1'b0;
    #1 check("fwd_mem", 32'(hif.fwd_A), 32'd2);
    step();

    // Load-use stall, then forward from MEM.
    set_idle();
    hif.rd_stage[0] = 5'd7;
    hif.regwrite_stage[0] = 1'b1;
    hif.rs2_decode = 5'd7;
    hif.rs2_used = 1'b1;
    #1 check("lu_stall", 32'(hif.stall_decode), 32'd1);
    check("lu_fwd", 32'(hif.fwd_B), 32'd0);
    step();
    hif.rd_stage = {5'd0, 5'd7, 5'd0};
    hif.regwrite_stage = 3'b010;
    hif.data_valid_stage = 3'b010;
    #1 check("lu_fwd_mem", 32'(hif.fwd_B), 32'd2);
    check("lu_release", 32'(hif.stall_decode), 32'd0);
    step();

    // Scoreboard: x9 busy for ten dependent cycles.
    do_reset();
    hif.lc_issue = 1'b1;
    hif.lc_rd = 5'd9;
    step();
    hif.lc_issue = 1'b0;
    hif.rs1_decode = 5'd9;
    hif.rs1_used = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        hif.lc_done = 1'b1;
        hif.lc_done_rd = 5'd9;
      end
      #1 check("sb_stall", 32'(hif.stall_decode), 32'd1);
      step();
    end
    hif.lc_done = 1'b0;
    #1 check("sb_release", 32'(hif.stall_decode), 32'd0);
    check("sb_count", 32'(hif.stall_count), 32'd10);
    step();

    // WAW on a pending destination.
    set_idle();
    hif.lc_issue = 1'b1;
    hif.lc_rd = 5'd9;
    step();
    #1 check("waw_stall", 32'(hif.stall_decode), 32'd1);
    step();
    set_idle();
    hif.lc_done = 1'b1;
    hif.lc_done_rd = 5'd9;
    step();

    // Same-cycle clear and issue of x4: set wins.
    set_idle();
    hif.lc_done = 1'b1;
    hif.lc_done_rd = 5'd4;
    hif.lc_issue = 1'b1;
    hif.lc_rd = 5'd4;
    step();
    set_idle();
    hif.rs2_decode = 5'd4;
    hif.rs2_used = 1'b1;
    #1 check("setwins_pend", 32'(hif.stall_decode), 32'd1);
    step();
    set_idle();
    hif.lc_done = 1'b1;
    hif.lc_done_rd = 5'd4;
    step();

    // Flush beats a load-use stall and blocks the issue.
    set_idle();
    hif.rd_stage[0] = 5'd7;
    hif.regwrite_stage[0] = 1'b1;
    hif.rs2_decode = 5'd7;
    hif.rs2_used = 1'b1;
    hif.branch_taken_exe = 1'b1;
    hif.lc_issue = 1'b1;
    hif.lc_rd = 5'd12;
    #1 check("flush_dec", 32'(hif.flush_decode), 32'd1);
    check("flush_ex", 32'(hif.flush_exe), 32'd1);
    check("flush_nostall", 32'(hif.stall_decode), 32'd0);
    step();
    set_idle();
    hif.rs1_decode = 5'd12;
    hif.rs1_used = 1'b1;
    #1 check("flush_noset", 32'(hif.stall_decode), 32'd0);
    step();

    // x0 never forwards or stalls.
    set_idle();
    hif.regwrite_stage[0] = 1'b1;
    hif.rs1_used = 1'b1;
    #1 check("x0_fwd", 32'(hif.fwd_A), 32'd0);
    check("x0_stall", 32'(hif.stall_decode), 32'd0);
    step();

    // Reset discards pending x3 and the counter.
    set_idle();
    hif.lc_issue = 1'b1;
    hif.lc_rd = 5'd3;
    step();
    set_idle();
    hif.rs1_decode = 5'd3;
    hif.rs1_used = 1'b1;
    #1 check("x3_pending", 32'(hif.stall_decode), 32'd1);
    step();
    rst = 1'b1;
    #1 check("rst_stall", 32'(hif.stall_decode), 32'd0);
    step();
    rst = 1'b0;
    #1 check("rst_x3_clear", 32'(hif.stall_decode), 32'd0);
    check("rst_count", 32'(hif.stall_count), 32'd0);
    step();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst                  = ($urandom_range(0, 99) == 0);
      hif.rs1_decode       = AW'($urandom_range(0, 7));
      hif.rs2_decode       = AW'($urandom_range(0, 7));
      hif.rs1_used         = 1'($urandom);
      hif.rs2_used         = 1'($urandom);
      for (int k = 0; k < NF; k++) hif.rd_stage[k] = AW'($urandom_range(0, 7));
      hif.regwrite_stage   = NF'($urandom);
      hif.data_valid_stage = NF'($urandom);
      hif.lc_issue         = ($urandom_range(0, 3) == 0);
      hif.lc_rd            = AW'($urandom_range(0, 7));
      hif.lc_done          = ($urandom_range(0, 3) == 0);
      hif.lc_done_rd       = AW'($urandom_range(0, 7));
      hif.branch_taken_exe = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
